// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ     = 100000000;
  localparam int unsigned DEF_BAUD       = 115200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // Sample ticks within a bit period that feed the majority vote.
  localparam int unsigned MID_LO = 7;
  localparam int unsigned MID    = 8;
  localparam int unsigned MID_HI = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  function automatic int unsigned tick_div_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one single-cycle tick every Div clocks while enabled.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned Div = 54
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned W = tick_div_width(Div);
  localparam logic [W-1:0] Last = W'(Div - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == Last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign tick_o = en_i && !restart_i && (cnt_q == Last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 3-sample majority vote and sticky ready/error flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic        CLK_100MHz,
  input  logic        reset,
  input  logic        clear,
  input  logic        RX,
  output logic [15:0] out,
  output logic        rx_ready,
  output logic        frame_err
);

  localparam int unsigned TICK_DIV =
      (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned SW = $clog2(OVERSAMPLE);

  rx_state_e   state_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [SW-1:0] smp_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [1:0]  votes_q;
  logic [7:0]  data_q;
  logic        rx_ready_q, frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic        parity_ok_q;
`endif

  logic tick, start_edge, mid_vote, vote;

  assign start_edge = rx_prev_q && !rx_sync_q;
  assign mid_vote   = tick && (smp_cnt_q == SW'(MID_HI));
  assign vote       = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_sync_q) |
                      (votes_q[1] & rx_sync_q);

  uart_baud_tick #(
    .Div(TICK_DIV)
  ) u_baud_tick (
    .clk_i    (CLK_100MHz),
    .rst_i    (reset),
    .en_i     (state_q != StIdle),
    .restart_i(state_q == StIdle && start_edge),
    .tick_o   (tick)
  );

  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      smp_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      votes_q     <= '0;
      data_q      <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;

      // Flag updates below are written later so a completion beats a clear.
      if (clear) begin
        rx_ready_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end

      if (tick) begin
        smp_cnt_q <= (smp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : smp_cnt_q + SW'(1);
        if (smp_cnt_q == SW'(MID_LO)) votes_q[0] <= rx_sync_q;
        if (smp_cnt_q == SW'(MID))    votes_q[1] <= rx_sync_q;
      end

      case (state_q)
        StIdle: begin
          smp_cnt_q <= '0;
          bit_idx_q <= '0;
          if (start_edge) state_q <= StStart;
        end
        StStart: begin
          if (mid_vote) state_q <= vote ? StIdle : StData;
        end
        StData: begin
          if (mid_vote) begin
            shift_q   <= {vote, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (mid_vote) begin
            parity_ok_q <= ((^shift_q) == vote);
            state_q     <= StStop;
          end
        end
`endif
        StStop: begin
          if (mid_vote) begin
            if (!vote) begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end else begin
              state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
              if (parity_ok_q) begin
                data_q     <= shift_q;
                rx_ready_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
`else
              data_q     <= shift_q;
              rx_ready_q <= 1'b1;
`endif
            end
          end
        end
        StBreak: begin
          if (rx_sync_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out       = {8'h00, data_q};
  assign rx_ready  = rx_ready_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames driven at 115200 baud on a 100 MHz clock.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int BIT_CLKS = 868;  // 100 MHz / 115200

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] out;
  logic        rx_ready;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  uart_rx_core dut (
    .CLK_100MHz(clk),
    .reset     (reset),
    .clear     (clear),
    .RX        (RX),
    .out       (out),
    .rx_ready  (rx_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    start_cyc = cyc;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_clks(BIT_CLKS);
    end
    RX = stop_bit;
    wait_clks(BIT_CLKS);
    RX = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    check("reset_out", out, 16'h0000);
    check("reset_ready", rx_ready, 1'b0);
    check("reset_err", frame_err, 1'b0);

    send_frame(8'h55, 1'b1);
    check("f55_out", out, 16'h0055);
    check("f55_ready", rx_ready, 1'b1);
    check("f55_err", frame_err, 1'b0);

    pulse_clear();
    check("clr_ready", rx_ready, 1'b0);
    check("clr_out", out, 16'h0055);

    // Short low glitch on an idle line must be rejected at the start-bit vote.
    @(negedge clk);
    RX = 1'b0;
    wait_clks(200);
    RX = 1'b1;
    wait_clks(1000);
    check("glitch_ready", rx_ready, 1'b0);
    check("glitch_out", out, 16'h0055);
    check("glitch_err", frame_err, 1'b0);

    send_frame(8'hA5, 1'b0);
    wait_clks(20);
    check("a5_err", frame_err, 1'b1);
    check("a5_ready", rx_ready, 1'b0);
    check("a5_out", out, 16'h0055);

    wait_clks(BIT_CLKS);
    send_frame(8'h3C, 1'b1);
    check("3c_out", out, 16'h003C);
    check("3c_ready", rx_ready, 1'b1);
    check("3c_err_sticky", frame_err, 1'b1);
    pulse_clear();
    check("3c_clr_err", frame_err, 1'b0);

    // Back-to-back frames; clear lands on the completion edge of the second.
    fork
      begin
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
      end
      begin : watch
        int s41, lat, tgt, t;
        wait_clks(10);
        s41 = start_cyc;
        for (t = 0; t < 20000 && out !== 16'h0041; t++) @(negedge clk);
        check("b2b_first_out", out, 16'h0041);
        lat = cyc - s41;
        check("latency_in_range", (lat >= 8200 && lat <= 8400), 1'b1);
        for (t = 0; t < 20000 && start_cyc == s41; t++) @(negedge clk);
        tgt = start_cyc + lat - 1;
        while (cyc < tgt) @(negedge clk);
        check("b2b_ready_before", rx_ready, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("b2b_ready_on_clear", rx_ready, 1'b1);
        check("b2b_second_out", out, 16'h0042);
        @(negedge clk);
        check("b2b_ready_after", rx_ready, 1'b1);
      end
    join
    check("b2b_final_out", out, 16'h0042);

    // Reset after data bit 3 of a frame aborts it.
    @(negedge clk);
    RX = 1'b0;
    wait_clks(5 * BIT_CLKS);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    RX = 1'b1;
    wait_clks(1);
    check("midrst_out", out, 16'h0000);
    check("midrst_ready", rx_ready, 1'b0);
    check("midrst_err", frame_err, 1'b0);

    wait_clks(2 * BIT_CLKS);
    send_frame(8'h81, 1'b1);
    check("81_out", out, 16'h0081);
    check("81_ready", rx_ready, 1'b1);
    check("81_err", frame_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
